// File: rtl/img_bank_pkg.sv
// Shared defaults and width helpers for the image line bank.
package img_bank_pkg;

  localparam int DEF_ROW_BITS = 3072;
  localparam int DEF_DEPTH    = 64;
  localparam int DEF_WIN      = 3;

  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int count_bits(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/img_bank_mem.sv
// Row storage: one write port, WIN registered window taps and one registered direct read.
// Define IMG_LINE_BANK_BYPASS_EN for write-first direct reads on a write collision.
module img_bank_mem #(
  parameter int ROW_BITS = 8,
  parameter int DEPTH    = 4,
  parameter int WIN      = 3,
  parameter int AW       = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [AW-1:0]           waddr,
  input  logic [ROW_BITS-1:0]     wdata,
  input  logic                    win_ld,
  input  logic [WIN*AW-1:0]       win_addr,
  output logic [WIN*ROW_BITS-1:0] win_q,
  input  logic                    dir_re,
  input  logic [AW-1:0]           dir_raddr,
  output logic [ROW_BITS-1:0]     dir_q
);

  logic [ROW_BITS-1:0]     mem [DEPTH];
  logic [WIN*ROW_BITS-1:0] win_q_d;
  logic [ROW_BITS-1:0]     dir_q_d;

  // The array itself is never reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    win_q_d = win_q;
    if (win_ld) begin
      for (int k = 0; k < WIN; k++)
        win_q_d[k*ROW_BITS +: ROW_BITS] = mem[win_addr[k*AW +: AW]];
    end
    dir_q_d = dir_q;
    if (dir_re) begin
`ifdef IMG_LINE_BANK_BYPASS_EN
      dir_q_d = (we && (waddr == dir_raddr)) ? wdata : mem[dir_raddr];
`else
      dir_q_d = mem[dir_raddr];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q <= '0;
      dir_q <= '0;
    end else begin
      win_q <= win_q_d;
      dir_q <= dir_q_d;
    end
  end

endmodule

// File: rtl/image_line_bank.sv
// Circular row buffer presenting a sliding WIN-row window plus a direct physical read port.
// Optional IMG_LINE_BANK_BYPASS_EN makes direct reads write-first on collision.
module image_line_bank
  import img_bank_pkg::*;
#(
  parameter int ROW_BITS = DEF_ROW_BITS,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int WIN      = DEF_WIN
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clr,
  input  logic                             wvalid,
  output logic                             wready,
  input  logic [ROW_BITS-1:0]              wdata,
  output logic                             win_valid,
  input  logic                             win_ready,
  output logic [WIN*ROW_BITS-1:0]          win_data,
  input  logic                             dir_re,
  input  logic [addr_bits(DEPTH)-1:0]      dir_raddr,
  output logic [ROW_BITS-1:0]              dir_rdata,
  output logic [count_bits(DEPTH)-1:0]     count
);

  localparam int AW = addr_bits(DEPTH);
  localparam int CW = count_bits(DEPTH);
  localparam logic [AW-1:0] AMASK = AW'(DEPTH - 1);

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, win_base;
  logic [CW-1:0]     count_q, count_d, count_eff;
  logic              win_valid_q, win_valid_d;
  logic              push, pop, load, mem_we;
  logic [WIN*AW-1:0] win_addr;

  assign wready    = count_q < CW'(DEPTH);
  assign win_valid = win_valid_q;
  assign count     = count_q;

  // A row pushed this cycle is not counted yet, so the window only sees committed rows.
  always_comb begin
    push      = wvalid && wready;
    pop       = win_valid_q && win_ready;
    count_eff = count_q - CW'(pop);
    load      = (count_eff >= CW'(WIN)) && (!win_valid_q || pop) && !clr;
    mem_we    = push && !clr;
    win_base  = pop ? ((rd_ptr_q + AW'(1)) & AMASK) : rd_ptr_q;
    win_addr  = '0;
    for (int k = 0; k < WIN; k++)
      win_addr[k*AW +: AW] = (win_base + AW'(k)) & AMASK;

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    win_valid_d = win_valid_q;
    if (clr) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      win_valid_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = (wr_ptr_q + AW'(1)) & AMASK;
      if (pop)  rd_ptr_d = (rd_ptr_q + AW'(1)) & AMASK;
      count_d = count_q + CW'(push) - CW'(pop);
      if (load)     win_valid_d = 1'b1;
      else if (pop) win_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      win_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      win_valid_q <= win_valid_d;
    end
  end

  img_bank_mem #(
    .ROW_BITS (ROW_BITS),
    .DEPTH    (DEPTH),
    .WIN      (WIN),
    .AW       (AW)
  ) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (mem_we),
    .waddr     (wr_ptr_q),
    .wdata     (wdata),
    .win_ld    (load),
    .win_addr  (win_addr),
    .win_q     (win_data),
    .dir_re    (dir_re),
    .dir_raddr (dir_raddr),
    .dir_q     (dir_rdata)
  );

endmodule

// File: tb/tb_image_line_bank.sv
// Directed self-checking bench for image_line_bank with ROW_BITS=8, DEPTH=4, WIN=3.
module tb_image_line_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        wvalid;
  logic        wready;
  logic [7:0]  wdata;
  logic        win_valid;
  logic        win_ready;
  logic [23:0] win_data;
  logic        dir_re;
  logic [1:0]  dir_raddr;
  logic [7:0]  dir_rdata;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  image_line_bank #(.ROW_BITS(8), .DEPTH(4), .WIN(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .wvalid    (wvalid),
    .wready    (wready),
    .wdata     (wdata),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_data  (win_data),
    .dir_re    (dir_re),
    .dir_raddr (dir_raddr),
    .dir_rdata (dir_rdata),
    .count     (count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then settle just after the rising edge.
  task automatic applyStimulus(input logic wv, input logic [7:0] wd, input logic rdy,
                               input logic c, input logic dre, input logic [1:0] dad);
    wvalid    = wv;
    wdata     = wd;
    win_ready = rdy;
    clr       = c;
    dir_re    = dre;
    dir_raddr = dad;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; wvalid = 1'b0; wdata = '0;
    win_ready = 1'b0; dir_re = 1'b0; dir_raddr = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    checkOutput("reset_count", 32'(count), 0);
    checkOutput("reset_valid", 32'(win_valid), 0);
    checkOutput("reset_wready", 32'(wready), 1);
    checkOutput("reset_wdata", 32'(win_data), 0);
    checkOutput("reset_dir", 32'(dir_rdata), 0);

    applyStimulus(1, 8'h11, 0, 0, 0, 0);
    checkOutput("push1_count", 32'(count), 1);
    applyStimulus(1, 8'h22, 0, 0, 0, 0);
    applyStimulus(1, 8'h33, 0, 0, 0, 0);
    checkOutput("push3_count", 32'(count), 3);
    checkOutput("push3_valid", 32'(win_valid), 0);
    applyStimulus(0, 8'h00, 0, 0, 0, 0);
    checkOutput("win1_valid", 32'(win_valid), 1);
    checkOutput("win1_data", 32'(win_data), 32'h332211);
    applyStimulus(0, 8'h00, 0, 0, 0, 0);
    checkOutput("win1_hold_valid", 32'(win_valid), 1);
    checkOutput("win1_hold_data", 32'(win_data), 32'h332211);

    applyStimulus(1, 8'h44, 0, 0, 0, 0);
    checkOutput("full_count", 32'(count), 4);
    checkOutput("full_wready", 32'(wready), 0);
    checkOutput("win1_still", 32'(win_data), 32'h332211);
    applyStimulus(0, 8'h00, 1, 0, 0, 0);
    checkOutput("win2_valid", 32'(win_valid), 1);
    checkOutput("win2_data", 32'(win_data), 32'h443322);
    checkOutput("pop1_count", 32'(count), 3);
    applyStimulus(0, 8'h00, 1, 0, 0, 0);
    checkOutput("pop2_valid", 32'(win_valid), 0);
    checkOutput("pop2_count", 32'(count), 2);

    applyStimulus(1, 8'h55, 0, 0, 0, 0);
    checkOutput("wrap_push_count", 32'(count), 3);
    checkOutput("wrap_push_valid", 32'(win_valid), 0);
    applyStimulus(1, 8'h66, 0, 0, 0, 0);
    checkOutput("win3_valid", 32'(win_valid), 1);
    checkOutput("win3_data", 32'(win_data), 32'h554433);
    checkOutput("refill_count", 32'(count), 4);
    checkOutput("refill_wready", 32'(wready), 0);
    applyStimulus(1, 8'h77, 0, 0, 0, 0);
    checkOutput("ignored_push_count", 32'(count), 4);
    checkOutput("ignored_push_data", 32'(win_data), 32'h554433);
    applyStimulus(0, 8'h00, 1, 0, 0, 0);
    checkOutput("win4_wrap_data", 32'(win_data), 32'h665544);
    checkOutput("win4_count", 32'(count), 3);

    applyStimulus(1, 8'h88, 1, 0, 0, 0);
    checkOutput("pushpop_count", 32'(count), 3);
    checkOutput("pushpop_valid", 32'(win_valid), 0);
    applyStimulus(0, 8'h00, 0, 0, 0, 0);
    checkOutput("win5_valid", 32'(win_valid), 1);
    checkOutput("win5_data", 32'(win_data), 32'h886655);

    applyStimulus(0, 8'h00, 0, 1, 0, 0);
    checkOutput("clr_valid", 32'(win_valid), 0);
    checkOutput("clr_count", 32'(count), 0);
    applyStimulus(0, 8'h00, 0, 0, 1, 0);
    checkOutput("clr_retained", 32'(dir_rdata), 32'h55);
    applyStimulus(0, 8'h00, 0, 0, 0, 1);
    checkOutput("dir_hold", 32'(dir_rdata), 32'h55);

    applyStimulus(1, 8'h11, 0, 0, 0, 0);
    applyStimulus(0, 8'h00, 0, 1, 0, 0);
    applyStimulus(1, 8'hAA, 0, 0, 1, 0);
`ifdef IMG_LINE_BANK_BYPASS_EN
    checkOutput("collision_dir", 32'(dir_rdata), 32'hAA);
`else
    checkOutput("collision_dir", 32'(dir_rdata), 32'h11);
`endif
    checkOutput("collision_count", 32'(count), 1);
    applyStimulus(0, 8'h00, 0, 0, 1, 0);
    checkOutput("after_collision_dir", 32'(dir_rdata), 32'hAA);

    applyStimulus(1, 8'hB1, 0, 0, 0, 0);
    applyStimulus(1, 8'hB2, 0, 0, 0, 0);
    applyStimulus(0, 8'h00, 0, 0, 0, 0);
    checkOutput("win6_data", 32'(win_data), 32'hB2B1AA);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", 32'(win_valid), 0);
    checkOutput("arst_count", 32'(count), 0);
    checkOutput("arst_wdata", 32'(win_data), 0);
    checkOutput("arst_dir", 32'(dir_rdata), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(0, 8'h00, 0, 0, 0, 0);
    checkOutput("post_rst_valid", 32'(win_valid), 0);
    checkOutput("post_rst_count", 32'(count), 0);
    applyStimulus(0, 8'h00, 0, 0, 1, 1);
    checkOutput("post_rst_mem", 32'(dir_rdata), 32'hB1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
